// File: rtl/res_ttl_pkg.sv
// Shared types and constants for the RES_TTL loop-test stimulus path.
// The checker side imports the same nominal pulse count.
package res_ttl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    BURST_HI,
    BURST_LO,
    DONE
  } stim_state_t;

  localparam int NUM_CH_DEF          = 8;
  localparam int ETALON_ISPR_RES_TTL = 50;
  localparam int PULSE_CNT_W         = 8;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ttl_burst_gen.sv
// Pulse-train engine for one burst: HALF_PERIOD high / HALF_PERIOD low,
// repeated target times. Exposes next-cycle level and the final-cycle flag.
module ttl_burst_gen
  import res_ttl_pkg::*;
#(
  parameter int HALF_PERIOD = 1,
  parameter int PH_W        = 1
) (
  input  logic                   clk_100Mz,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   go,
  input  logic [PULSE_CNT_W-1:0] target,
  output logic                   pulse_nxt,
  output logic                   last
);

  localparam int CW1 = PULSE_CNT_W + 1;

  logic                   active_q;
  logic                   pulse_q;
  logic [PH_W-1:0]        ph_q;
  logic [PULSE_CNT_W-1:0] pls_q;
  logic [CW1-1:0]         pls_inc;
  logic                   phase_end;
  logic                   fin;

  // Outputs depend on registers only, so the parent FSM may use them freely.
  always_comb begin
    pls_inc   = {1'b0, pls_q} + CW1'(1);
    phase_end = (ph_q == PH_W'(HALF_PERIOD - 1));
    fin       = (pls_inc >= {1'b0, target});
    last      = active_q && !pulse_q && phase_end && fin;
    pulse_nxt = active_q && (phase_end ? (!pulse_q && !fin) : pulse_q);
  end

  always_ff @(posedge clk_100Mz) begin
    if (rst || clr) begin
      active_q <= 1'b0;
      pulse_q  <= 1'b0;
      ph_q     <= '0;
      pls_q    <= '0;
    end else if (go) begin
      active_q <= 1'b1;
      pulse_q  <= 1'b1;
      ph_q     <= '0;
      pls_q    <= '0;
    end else if (active_q) begin
      if (phase_end) begin
        ph_q    <= '0;
        pulse_q <= pulse_nxt;
        if (!pulse_q) begin
          pls_q <= pls_inc[PULSE_CNT_W-1:0];
          if (fin) active_q <= 1'b0;
        end
      end else begin
        ph_q <= ph_q + PH_W'(1);
      end
    end
  end

endmodule

// File: rtl/res_ttl_stim_gen.sv
// RES_TTL loop-test transmitter: per frame, each channel in turn gets a gap
// then a burst of cnt_target pulses; other lines stay low so shorts show up.
module res_ttl_stim_gen
  import res_ttl_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int HALF_PERIOD = 1,
  parameter int GAP_CYCLES  = 16,
  parameter int FRAMES      = 8
) (
  input  logic                      clk_100Mz,
  input  logic                      rst,
  input  logic                      start,
  input  logic [PULSE_CNT_W-1:0]    pulse_count,
  input  logic                      abort,
  output logic [NUM_CH-1:0]         res_ttl_drive,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      burst_active,
  output logic                      busy,
  output logic                      done
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int PH_W = cnt_w((HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES);
  localparam int FR_W = $clog2(FRAMES + 1);

  stim_state_t            state_q, state_n;
  logic [PH_W-1:0]        ph_q, ph_n;
  logic [CH_W-1:0]        ch_q, ch_n;
  logic [FR_W-1:0]        fr_q, fr_n;
  logic [PULSE_CNT_W-1:0] tgt_q, tgt_n;
  logic                   go, clr, end_slot;
  logic                   pulse_nxt, last;
  logic                   busy_n;

  ttl_burst_gen #(
    .HALF_PERIOD (HALF_PERIOD),
    .PH_W        (PH_W)
  ) u_burst (
    .clk_100Mz (clk_100Mz),
    .rst       (rst),
    .clr       (clr),
    .go        (go),
    .target    (tgt_q),
    .pulse_nxt (pulse_nxt),
    .last      (last)
  );

  always_comb begin
    state_n  = state_q;
    ph_n     = ph_q;
    ch_n     = ch_q;
    fr_n     = fr_q;
    tgt_n    = tgt_q;
    go       = 1'b0;
    clr      = 1'b0;
    end_slot = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        tgt_n   = pulse_count;
        ch_n    = '0;
        fr_n    = '0;
        ph_n    = '0;
        state_n = GAP;
      end
      GAP: begin
        if (ph_q == PH_W'(GAP_CYCLES - 1)) begin
          ph_n = '0;
          if (tgt_q != '0) begin
            go      = 1'b1;
            state_n = BURST_HI;
          end else begin
            end_slot = 1'b1;
          end
        end else begin
          ph_n = ph_q + PH_W'(1);
        end
      end
      BURST_HI, BURST_LO: begin
        if (last) end_slot = 1'b1;
        else      state_n  = pulse_nxt ? BURST_HI : BURST_LO;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (end_slot) begin
      if (ch_q != CH_W'(NUM_CH - 1)) begin
        ch_n    = ch_q + CH_W'(1);
        state_n = GAP;
      end else begin
        ch_n    = '0;
        fr_n    = fr_q + FR_W'(1);
        state_n = ((fr_q + FR_W'(1)) < FR_W'(FRAMES)) ? GAP : DONE;
      end
    end
    // Abort beats everything, including the last slot turning into DONE.
    if (abort && (state_q != IDLE)) begin
      state_n = IDLE;
      ch_n    = '0;
      fr_n    = '0;
      ph_n    = '0;
      go      = 1'b0;
      clr     = 1'b1;
    end
    busy_n = (state_n == GAP) || (state_n == BURST_HI) || (state_n == BURST_LO);
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk_100Mz) begin
    if (rst) begin
      state_q       <= IDLE;
      ph_q          <= '0;
      ch_q          <= '0;
      fr_q          <= '0;
      tgt_q         <= '0;
      res_ttl_drive <= '0;
      ch_sel        <= '0;
      burst_active  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_n;
      ph_q          <= ph_n;
      ch_q          <= ch_n;
      fr_q          <= fr_n;
      tgt_q         <= tgt_n;
      res_ttl_drive <= (state_n == BURST_HI) ? (NUM_CH'(1) << ch_n) : '0;
      ch_sel        <= busy_n ? ch_n : '0;
      burst_active  <= (state_n == BURST_HI) || (state_n == BURST_LO);
      busy          <= busy_n;
      done          <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_res_ttl_stim_gen.sv
// Scoreboard bench: runs push expected done cycle and per-channel edge counts;
// a monitor pops on every done pulse. Instance 0 defaults, instance 1 HP=2/FRAMES=1.
module tb_res_ttl_stim_gen;
  import res_ttl_pkg::*;

  localparam int NCH = 8;

  typedef struct {
    int done_cyc;
    int rises;
  } exp_t;

  logic clk_100Mz = 1'b0;
  always #5 clk_100Mz = ~clk_100Mz;

  int cyc = 0;
  always @(posedge clk_100Mz) cyc <= cyc + 1;

  logic           rst   [2];
  logic           start [2];
  logic           abort [2];
  logic [7:0]     pc    [2];
  logic [NCH-1:0] drive [2];
  logic [2:0]     ch_sel[2];
  logic           bact  [2];
  logic           busy  [2];
  logic           done  [2];

  res_ttl_stim_gen #(.NUM_CH(NCH), .HALF_PERIOD(1), .GAP_CYCLES(16), .FRAMES(8)) u_a (
    .clk_100Mz(clk_100Mz), .rst(rst[0]), .start(start[0]), .pulse_count(pc[0]),
    .abort(abort[0]), .res_ttl_drive(drive[0]), .ch_sel(ch_sel[0]),
    .burst_active(bact[0]), .busy(busy[0]), .done(done[0]));

  res_ttl_stim_gen #(.NUM_CH(NCH), .HALF_PERIOD(2), .GAP_CYCLES(16), .FRAMES(1)) u_b (
    .clk_100Mz(clk_100Mz), .rst(rst[1]), .start(start[1]), .pulse_count(pc[1]),
    .abort(abort[1]), .res_ttl_drive(drive[1]), .ch_sel(ch_sel[1]),
    .burst_active(bact[1]), .busy(busy[1]), .done(done[1]));

  int   checks   = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  bit   b_fin = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? qa.size() : qb.size();
  endfunction

  // ---------------- monitor ----------------
  int           rises  [2][NCH];
  bit [NCH-1:0] prev   [2];
  bit           bprev  [2];
  bit           dprev  [2];
  int           hi_run [2];

  always @(negedge clk_100Mz) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (busy[i] && !bprev[i])
        for (int c = 0; c < NCH; c++) rises[i][c] = 0;
      if (drive[i] != '0) chk($sformatf("onehot_i%0d", i), $countones(drive[i]), 1);
      for (int c = 0; c < NCH; c++)
        if (drive[i][c] && !prev[i][c]) rises[i][c]++;
      if (drive[i] != '0) hi_run[i]++;
      else if (prev[i] != '0) begin
        chk($sformatf("pulse_width_i%0d", i), hi_run[i], (i == 0) ? 1 : 2);
        hi_run[i] = 0;
      end
      if (dprev[i]) chk($sformatf("done_width_i%0d", i), int'(done[i]), 0);
      if (done[i]) begin
        if (qsize(i) == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done_i%0d actual=done at cycle %0d required=no done", i, cyc);
        end else begin
          if (i == 0) e = qa.pop_front();
          else        e = qb.pop_front();
          chk($sformatf("done_cycle_i%0d", i), cyc, e.done_cyc);
          for (int c = 0; c < NCH; c++) begin
            chk($sformatf("rises_i%0d_ch%0d", i, c), rises[i][c], e.rises);
            rises[i][c] = 0;
          end
        end
      end
      prev[i]  = drive[i];
      bprev[i] = busy[i];
      dprev[i] = done[i];
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_until(input int tgt);
    while (cyc < tgt) @(negedge clk_100Mz);
  endtask

  task automatic wait_drain(input int i, input int budget);
    int k;
    k = 0;
    while (qsize(i) != 0 && k < budget) begin
      @(negedge clk_100Mz);
      k++;
    end
    checks++;
    if (qsize(i) != 0) begin
      failures++;
      $display("FAIL timeout_i%0d actual=%0d pending runs required=0", i, qsize(i));
    end
    @(negedge clk_100Mz);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_drive"}, int'(drive[0]), 0);
    chk({tag, "_ch_sel"}, int'(ch_sel[0]), 0);
    chk({tag, "_burst_active"}, int'(bact[0]), 0);
    chk({tag, "_busy"}, int'(busy[0]), 0);
    chk({tag, "_done"}, int'(done[0]), 0);
  endtask

  // ---------------- instance 1: 255 pulses, 2 high / 2 low ----------------
  initial begin
    int n;
    rst[1] = 1'b1; start[1] = 1'b0; abort[1] = 1'b0; pc[1] = 8'd0;
    repeat (3) @(negedge clk_100Mz);
    rst[1] = 1'b0;
    @(negedge clk_100Mz);
    n = cyc;
    pc[1] = 8'd255;
    start[1] = 1'b1;
    qb.push_back('{n + 8 * (16 + 1020) + 1, 255});
    @(negedge clk_100Mz);
    start[1] = 1'b0;
    wait_drain(1, 10000);
    b_fin = 1'b1;
  end

  // ---------------- instance 0: directed scenarios ----------------
  initial begin
    int n, n2, k;
    rst[0] = 1'b1; start[0] = 1'b0; abort[0] = 1'b0; pc[0] = 8'd0;
    repeat (3) @(negedge clk_100Mz);
    chk_idle("reset");
    rst[0] = 1'b0;
    @(negedge clk_100Mz);

    // nominal run
    n = cyc;
    pc[0] = 8'(ETALON_ISPR_RES_TTL);
    start[0] = 1'b1;
    qa.push_back('{n + 7425, 400});
    @(negedge clk_100Mz);
    start[0] = 1'b0;
    chk("busy_c1", int'(busy[0]), 1);
    wait_until(n + 16);
    chk("drive_c16", int'(drive[0]), 0);
    @(negedge clk_100Mz);
    chk("drive_c17", int'(drive[0]), 1);
    chk("burst_active_c17", int'(bact[0]), 1);
    chk("ch_sel_c17", int'(ch_sel[0]), 0);
    wait_until(n + 133);
    chk("ch_sel_c133", int'(ch_sel[0]), 1);
    chk("drive_c133", int'(drive[0]), 2);
    wait_drain(0, 9000);

    // zero pulse count: gaps only
    n = cyc;
    pc[0] = 8'd0;
    start[0] = 1'b1;
    qa.push_back('{n + 1025, 0});
    @(negedge clk_100Mz);
    start[0] = 1'b0;
    wait_drain(0, 2000);

    // abort at cycle 500, new start at 510
    n = cyc;
    pc[0] = 8'd50;
    start[0] = 1'b1;
    @(negedge clk_100Mz);
    start[0] = 1'b0;
    wait_until(n + 500);
    abort[0] = 1'b1;
    @(negedge clk_100Mz);
    abort[0] = 1'b0;
    chk_idle("abort");
    wait_until(n + 510);
    n2 = cyc;
    pc[0] = 8'd0;
    start[0] = 1'b1;
    qa.push_back('{n2 + 1025, 0});
    @(negedge clk_100Mz);
    start[0] = 1'b0;
    chk("busy_after_abort_start", int'(busy[0]), 1);
    wait_drain(0, 2000);

    // reset held 3 cycles mid-burst
    n = cyc;
    pc[0] = 8'd50;
    start[0] = 1'b1;
    @(negedge clk_100Mz);
    start[0] = 1'b0;
    wait_until(n + 200);
    chk("burst_active_c200", int'(bact[0]), 1);
    rst[0] = 1'b1;
    @(negedge clk_100Mz);
    chk_idle("midrun_reset");
    repeat (2) @(negedge clk_100Mz);
    rst[0] = 1'b0;
    n2 = cyc;
    pc[0] = 8'd0;
    start[0] = 1'b1;
    qa.push_back('{n2 + 1025, 0});
    @(negedge clk_100Mz);
    start[0] = 1'b0;
    wait_drain(0, 2000);

    // start held high, pulse_count changed mid-run: two back-to-back runs
    n = cyc;
    pc[0] = 8'd3;
    start[0] = 1'b1;
    qa.push_back('{n + 1409, 24});
    qa.push_back('{n + 2563, 8});
    wait_until(n + 300);
    pc[0] = 8'd1;
    wait_until(n + 1500);
    start[0] = 1'b0;
    wait_drain(0, 3000);
    repeat (3) @(negedge clk_100Mz);
    chk("no_third_run_busy", int'(busy[0]), 0);

    k = 0;
    while (!b_fin && k < 20000) begin
      @(negedge clk_100Mz);
      k++;
    end
    chk("inst1_finished", int'(b_fin), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
